dmem_arbiter: RTL and testbench

Shares the single data RAM between two requesters: the core's memory stage (port C) and an external loader/debug port (port X). Core has fixed priority. A starvation counter forces one X grant after X has waited `STARVE_LIMIT` consecutive cycles. The block stalls the pipeline while the core is denied, and routes the one-cycle-latency read data back to whichever port issued the read.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 68 ++++++
 tb/tb_dmem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-RAM arbiter, its two requesters (core C, external X) and the RAM.
// The slave modport is the arbiter's view; the master modport is the requesters/RAM side.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;
  logic              stall_o;

  logic              x_req;
  logic              x_we;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_wdata;
  logic              x_gnt;
  logic              x_rvalid;
  logic [DATA_W-1:0] x_rdata;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, stall_o,
    input  x_req, x_we, x_addr, x_wdata,
    output x_gnt, x_rvalid, x_rdata,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, stall_o,
    output x_req, x_we, x_addr, x_wdata,
    input  x_gnt, x_rvalid, x_rdata,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: core has fixed priority, the external port is forced through after
// STARVE_LIMIT consecutive denied cycles; one-cycle read data is steered back to its issuer.
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        r_wait_cnt;
  logic              r_rd_pend;
  logic              r_rd_own;

  logic              w_force;
  logic              w_x_gnt;
  logic              w_c_gnt;
  logic              w_rd_issue;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // Grants are suppressed while reset is low so the RAM can never be written then.
  assign w_force    = bus.x_req & (r_wait_cnt == LIMIT);
  assign w_x_gnt    = reset & bus.x_req & (~bus.c_req | w_force);
  assign w_c_gnt    = reset & bus.c_req & ~w_x_gnt;
  assign w_rd_issue = (w_c_gnt & ~bus.c_we) | (w_x_gnt & ~bus.x_we);

  assign w_addr  = w_x_gnt ? bus.x_addr  : bus.c_addr;
  assign w_wdata = w_x_gnt ? bus.x_wdata : bus.c_wdata;

  assign bus.c_gnt     = w_c_gnt;
  assign bus.x_gnt     = w_x_gnt;
  assign bus.stall_o   = bus.c_req & ~w_c_gnt;
  assign bus.ram_we    = (w_c_gnt & bus.c_we) | (w_x_gnt & bus.x_we);
  assign bus.ram_addr  = w_addr;
  assign bus.ram_wdata = w_wdata;

  assign bus.c_rvalid = r_rd_pend & ~r_rd_own;
  assign bus.x_rvalid = r_rd_pend & r_rd_own;
  assign bus.c_rdata  = bus.ram_rdata;
  assign bus.x_rdata  = bus.ram_rdata;

  // Counts consecutive denied X cycles; an X abort (req dropped) restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= 4'd0;
    end else if (w_x_gnt || !bus.x_req) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt != LIMIT) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_pend <= 1'b0;
      r_rd_own  <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_issue;
      r_rd_own  <= w_x_gnt;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a one-cycle-latency RAM model preloaded with 0xA000_0000+index.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [31:0] mem [0:255];

  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed RAM: write at the edge, read data registered for the next cycle.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr[9:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveC(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata;
  endtask

  task automatic driveX(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.x_req = req; bus.x_we = we; bus.x_addr = addr; bus.x_wdata = wdata;
  endtask

  task automatic test_reset();
    driveC(1'b1, 1'b1, 32'h10, 32'h1111_1111);
    driveX(1'b1, 1'b1, 32'h20, 32'h2222_2222);
    @(negedge clk);
    checks++; if (bus.c_gnt !== 1'b0) begin failures++; $display("[TB] FAIL rst_c_gnt got=%b exp=0", bus.c_gnt); end
    checks++; if (bus.x_gnt !== 1'b0) begin failures++; $display("[TB] FAIL rst_x_gnt got=%b exp=0", bus.x_gnt); end
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_ram_we got=%b exp=0", bus.ram_we); end
    checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_stall got=%b exp=1", bus.stall_o); end
    checks++; if (bus.c_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_c_rvalid got=%b exp=0", bus.c_rvalid); end
    checks++; if (bus.x_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_x_rvalid got=%b exp=0", bus.x_rvalid); end
    driveC(1'b0, 1'b0, 32'h0, 32'h0);
    driveX(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_core_rw();
    driveC(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    checks++; if (bus.c_gnt !== 1'b1) begin failures++; $display("[TB] FAIL crw_gnt0 got=%b exp=1", bus.c_gnt); end
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL crw_stall0 got=%b exp=0", bus.stall_o); end
    checks++; if (bus.x_gnt !== 1'b0) begin failures++; $display("[TB] FAIL crw_xgnt0 got=%b exp=0", bus.x_gnt); end
    checks++; if (bus.ram_addr !== 32'h10) begin failures++; $display("[TB] FAIL crw_addr0 got=%h exp=00000010", bus.ram_addr); end
    checks++; if (bus.c_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL crw_rvalid0 got=%b exp=0", bus.c_rvalid); end
    tick();
    driveC(1'b1, 1'b1, 32'h14, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++; if (bus.c_gnt !== 1'b1) begin failures++; $display("[TB] FAIL crw_gnt1 got=%b exp=1", bus.c_gnt); end
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL crw_stall1 got=%b exp=0", bus.stall_o); end
    checks++; if (bus.ram_we !== 1'b1) begin failures++; $display("[TB] FAIL crw_we1 got=%b exp=1", bus.ram_we); end
    checks++; if (bus.ram_wdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL crw_wdata1 got=%h exp=deadbeef", bus.ram_wdata); end
    checks++; if (bus.c_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL crw_rvalid1 got=%b exp=1", bus.c_rvalid); end
    checks++; if (bus.x_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL crw_xrvalid1 got=%b exp=0", bus.x_rvalid); end
    checks++; if (bus.c_rdata !== 32'hA000_0004) begin failures++; $display("[TB] FAIL crw_rdata1 got=%h exp=a0000004", bus.c_rdata); end
    tick();
    driveC(1'b1, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    checks++; if (bus.c_gnt !== 1'b1) begin failures++; $display("[TB] FAIL crw_gnt2 got=%b exp=1", bus.c_gnt); end
    checks++; if (bus.c_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL crw_rvalid2 got=%b exp=0", bus.c_rvalid); end
    tick();
    driveC(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.c_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL crw_rvalid3 got=%b exp=1", bus.c_rvalid); end
    checks++; if (bus.c_rdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL crw_rdata3 got=%h exp=deadbeef", bus.c_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    logic prevX;
    logic expX;
    prevX = 1'b0;
    driveC(1'b1, 1'b1, 32'h20, 32'h5555_0000);
    driveX(1'b1, 1'b0, 32'h24, 32'h0);
    for (int k = 0; k < 10; k++) begin
      expX = ((k % 5) == 4);
      @(negedge clk);
      checks++; if (bus.x_gnt !== expX) begin failures++; $display("[TB] FAIL starve_xgnt k=%0d got=%b exp=%b", k, bus.x_gnt, expX); end
      checks++; if (bus.c_gnt !== !expX) begin failures++; $display("[TB] FAIL starve_cgnt k=%0d got=%b exp=%b", k, bus.c_gnt, !expX); end
      checks++; if (bus.stall_o !== expX) begin failures++; $display("[TB] FAIL starve_stall k=%0d got=%b exp=%b", k, bus.stall_o, expX); end
      checks++; if (bus.ram_we !== !expX) begin failures++; $display("[TB] FAIL starve_we k=%0d got=%b exp=%b", k, bus.ram_we, !expX); end
      checks++; if (bus.ram_addr !== (expX ? 32'h24 : 32'h20)) begin failures++; $display("[TB] FAIL starve_addr k=%0d got=%h", k, bus.ram_addr); end
      checks++; if (bus.x_rvalid !== prevX) begin failures++; $display("[TB] FAIL starve_xrvalid k=%0d got=%b exp=%b", k, bus.x_rvalid, prevX); end
      checks++; if (bus.c_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL starve_crvalid k=%0d got=%b exp=0", k, bus.c_rvalid); end
      prevX = expX;
      tick();
    end
    driveC(1'b0, 1'b0, 32'h0, 32'h0);
    driveX(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.x_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL starve_last_xrvalid got=%b exp=1", bus.x_rvalid); end
    checks++; if (bus.x_rdata !== 32'hA000_0009) begin failures++; $display("[TB] FAIL starve_last_xrdata got=%h exp=a0000009", bus.x_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    driveX(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    checks++; if (bus.x_gnt !== 1'b1) begin failures++; $display("[TB] FAIL b2b_xgnt got=%b exp=1", bus.x_gnt); end
    tick();
    driveX(1'b0, 1'b0, 32'h0, 32'h0);
    driveC(1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    checks++; if (bus.c_gnt !== 1'b1) begin failures++; $display("[TB] FAIL b2b_cgnt got=%b exp=1", bus.c_gnt); end
    checks++; if (bus.x_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_xrvalid1 got=%b exp=1", bus.x_rvalid); end
    checks++; if (bus.c_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_crvalid1 got=%b exp=0", bus.c_rvalid); end
    checks++; if (bus.x_rdata !== 32'hA000_0010) begin failures++; $display("[TB] FAIL b2b_xrdata got=%h exp=a0000010", bus.x_rdata); end
    tick();
    driveC(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.c_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_crvalid2 got=%b exp=1", bus.c_rvalid); end
    checks++; if (bus.x_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_xrvalid2 got=%b exp=0", bus.x_rvalid); end
    checks++; if (bus.c_rdata !== 32'hA000_0011) begin failures++; $display("[TB] FAIL b2b_crdata got=%h exp=a0000011", bus.c_rdata); end
    tick();
  endtask

  task automatic test_x_write();
    driveX(1'b1, 1'b1, 32'h80, 32'h1234_5678);
    @(negedge clk);
    checks++; if (bus.x_gnt !== 1'b1) begin failures++; $display("[TB] FAIL xw_gnt got=%b exp=1", bus.x_gnt); end
    checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL xw_stall got=%b exp=0", bus.stall_o); end
    checks++; if (bus.ram_we !== 1'b1) begin failures++; $display("[TB] FAIL xw_we got=%b exp=1", bus.ram_we); end
    checks++; if (bus.ram_addr !== 32'h80) begin failures++; $display("[TB] FAIL xw_addr got=%h exp=00000080", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 32'h1234_5678) begin failures++; $display("[TB] FAIL xw_wdata got=%h exp=12345678", bus.ram_wdata); end
    tick();
    driveX(1'b0, 1'b0, 32'h0, 32'h0);
    driveC(1'b1, 1'b0, 32'h80, 32'h0);
    @(negedge clk);
    checks++; if (bus.c_gnt !== 1'b1) begin failures++; $display("[TB] FAIL xw_cgnt got=%b exp=1", bus.c_gnt); end
    checks++; if (bus.x_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL xw_xrvalid got=%b exp=0", bus.x_rvalid); end
    tick();
    driveC(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.c_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL xw_crvalid got=%b exp=1", bus.c_rvalid); end
    checks++; if (bus.c_rdata !== 32'h1234_5678) begin failures++; $display("[TB] FAIL xw_crdata got=%h exp=12345678", bus.c_rdata); end
    tick();
  endtask

  task automatic test_reset_midread();
    logic expX;
    driveC(1'b1, 1'b0, 32'h10, 32'h0);
    driveX(1'b1, 1'b0, 32'h24, 32'h0);
    @(negedge clk);
    checks++; if (bus.c_gnt !== 1'b1) begin failures++; $display("[TB] FAIL rmr_cgnt0 got=%b exp=1", bus.c_gnt); end
    tick();
    @(negedge clk);
    checks++; if (bus.c_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL rmr_crvalid1 got=%b exp=1", bus.c_rvalid); end
    tick();
    reset = 1'b0;
    bus.c_we = 1'b1;
    bus.x_we = 1'b1;
    @(negedge clk);
    checks++; if (bus.c_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rmr_crvalid_rst got=%b exp=0", bus.c_rvalid); end
    checks++; if (bus.x_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rmr_xrvalid_rst got=%b exp=0", bus.x_rvalid); end
    checks++; if (bus.ram_we !== 1'b0) begin failures++; $display("[TB] FAIL rmr_we_rst got=%b exp=0", bus.ram_we); end
    checks++; if (bus.x_gnt !== 1'b0) begin failures++; $display("[TB] FAIL rmr_xgnt_rst got=%b exp=0", bus.x_gnt); end
    checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("[TB] FAIL rmr_stall_rst got=%b exp=1", bus.stall_o); end
    tick();
    reset = 1'b1;
    bus.c_we = 1'b0;
    bus.x_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expX = (k == 4);
      @(negedge clk);
      checks++; if (bus.x_gnt !== expX) begin failures++; $display("[TB] FAIL rmr_xgnt k=%0d got=%b exp=%b", k, bus.x_gnt, expX); end
      checks++; if (bus.stall_o !== expX) begin failures++; $display("[TB] FAIL rmr_stall k=%0d got=%b exp=%b", k, bus.stall_o, expX); end
      if (k == 0) begin
        checks++; if (bus.c_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rmr_crvalid_post got=%b exp=0", bus.c_rvalid); end
      end
      tick();
    end
    driveC(1'b0, 1'b0, 32'h0, 32'h0);
    driveX(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus.x_rvalid !== 1'b1) begin failures++; $display("[TB] FAIL rmr_xrvalid_end got=%b exp=1", bus.x_rvalid); end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    reset = 1'b0;
    bus.ram_rdata = 32'h0;
    driveC(1'b0, 1'b0, 32'h0, 32'h0);
    driveX(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    test_reset();
    test_core_rw();
    test_starvation();
    test_back_to_back();
    test_x_write();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
